// File: rtl/note_sequencer_if.sv
// note_sequencer_if
// Groups the song-load bus, detected-note stream, frame strobe and display
// outputs of the note sequencer into one bundle.
//   wr_en/wr_addr/wr_data : song RAM write port (driver -> sequencer)
//   song_len/start        : song length and start/restart request
//   note_in/note_valid    : detected note sample stream
//   frame_start           : vertical blanking pulse
//   past/current/future   : display note codes (sequencer -> display)
//   busy/song_done        : play status
//   miss_cnt              : saturating wrong-note counter
interface note_sequencer_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [5:0] wr_data;
  logic [6:0] song_len;
  logic       start;
  logic [5:0] note_in;
  logic       note_valid;
  logic       frame_start;
  logic [5:0] past;
  logic [5:0] current;
  logic [5:0] future;
  logic       busy;
  logic       song_done;
  logic [7:0] miss_cnt;

  // Sequencer side
  modport slave (
    input  wr_en, wr_addr, wr_data, song_len, start,
    input  note_in, note_valid, frame_start,
    output past, current, future, busy, song_done, miss_cnt
  );

  // Driver / display side
  modport master (
    output wr_en, wr_addr, wr_data, song_len, start,
    output note_in, note_valid, frame_start,
    input  past, current, future, busy, song_done, miss_cnt
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer
// Play-along song sequencer. Holds a song of up to DEPTH 6-bit note codes,
// compares the detected-note stream against the current note and advances
// after HOLD consecutive matching samples. Display codes (past/current/
// future) are published only on frame_start so the display never tears.
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : note_sequencer_if.slave (write port, note stream, display)
module note_sequencer #(
  parameter int DEPTH = 64,
  parameter int HOLD  = 4
) (
  input  logic            clk,
  input  logic            reset,
  note_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, LISTEN, FETCH, DONE} state_t;

  state_t     state;
  state_t     state_next;

  logic [5:0] mem [DEPTH];
  logic [5:0] rd_data;
  logic       rd_en;
  logic [5:0] rd_addr;

  logic [6:0] idx;
  logic [6:0] len;
  logic [5:0] cur_n;
  logic [5:0] next_n;
  logic [5:0] prev_n;
  logic [3:0] match_cnt;
  logic [7:0] miss_q;
  logic       done_q;
  logic [5:0] past_q;
  logic [5:0] current_q;
  logic [5:0] future_q;

  logic       busy;
  logic       start_ok;
  logic       sample_match;
  logic       hit;
  logic       last;
  logic [6:0] idx_plus2;

  assign busy         = (state == PRIME0) || (state == PRIME1) ||
                        (state == LISTEN) || (state == FETCH);
  assign start_ok     = bus.start && (bus.song_len >= 7'd1) &&
                        (bus.song_len <= 7'(DEPTH));
  assign sample_match = (bus.note_in == cur_n);
  assign hit          = (state == LISTEN) && bus.note_valid && sample_match &&
                        (match_cnt == 4'(HOLD - 1));
  assign last         = (idx == len - 7'd1);
  assign idx_plus2    = idx + 7'd2;

  // Song RAM: writes are locked out while a song is playing; reads are
  // registered so every read address lands in rd_data one cycle later.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy)
      mem[bus.wr_addr] <= bus.wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and RAM read control. A read is issued one state ahead of
  // the state that consumes it to cover the RAM latency.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    rd_addr    = 6'd0;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_next = PRIME0;
          rd_en      = 1'b1;
          rd_addr    = 6'd0;
        end
      end
      PRIME0: begin
        state_next = PRIME1;
        if (len > 7'd1) begin
          rd_en   = 1'b1;
          rd_addr = 6'd1;
        end
      end
      PRIME1: state_next = LISTEN;
      LISTEN: begin
        if (hit) begin
          if (last) begin
            state_next = DONE;
          end else begin
            state_next = FETCH;
            if (idx_plus2 < len) begin
              rd_en   = 1'b1;
              rd_addr = idx_plus2[5:0];
            end
          end
        end
      end
      FETCH:   state_next = LISTEN;
      default: state_next = IDLE;
    endcase
  end

  // Song position, note window and scoring. The final hit blanks cur/next
  // so the display shows the song has ended; song_done is a registered
  // one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 7'd0;
      len       <= 7'd0;
      cur_n     <= 6'd0;
      next_n    <= 6'd0;
      prev_n    <= 6'd0;
      match_cnt <= 4'd0;
      miss_q    <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            len       <= bus.song_len;
            idx       <= 7'd0;
            prev_n    <= 6'd0;
            miss_q    <= 8'd0;
            match_cnt <= 4'd0;
          end
        end
        PRIME0: cur_n <= rd_data;
        PRIME1: next_n <= (len > 7'd1) ? rd_data : 6'd0;
        LISTEN: begin
          if (bus.note_valid) begin
            if (sample_match) begin
              if (hit) begin
                prev_n    <= cur_n;
                match_cnt <= 4'd0;
                if (last) begin
                  cur_n  <= 6'd0;
                  next_n <= 6'd0;
                  done_q <= 1'b1;
                end else begin
                  cur_n <= next_n;
                  idx   <= idx + 7'd1;
                end
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              match_cnt <= 4'd0;
              if ((bus.note_in != 6'd0) && (miss_q != 8'hFF))
                miss_q <= miss_q + 8'd1;
            end
          end
        end
        FETCH: next_n <= (idx + 7'd1 < len) ? rd_data : 6'd0;
        default: ;
      endcase
    end
  end

  // Display register set. Non-blocking capture means a frame_start that
  // coincides with an internal update publishes the pre-update values.
  always_ff @(posedge clk) begin
    if (reset) begin
      past_q    <= 6'd0;
      current_q <= 6'd0;
      future_q  <= 6'd0;
    end else if (bus.frame_start) begin
      past_q    <= prev_n;
      current_q <= cur_n;
      future_q  <= next_n;
    end
  end

  assign bus.past      = past_q;
  assign bus.current   = current_q;
  assign bus.future    = future_q;
  assign bus.busy      = busy;
  assign bus.song_done = done_q;
  assign bus.miss_cnt  = miss_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// Self-checking bench for note_sequencer: a directed vector table for the
// play-through scenario, hand-written reset sequences, and a randomized run
// checked against a song-level reference model.
module tb_note_sequencer;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  note_sequencer_if bus();

  note_sequencer #(.DEPTH(64), .HOLD(HOLD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         n;
    logic       wr;
    logic [5:0] wa;
    logic [5:0] wd;
    logic       st;
    logic [6:0] len;
    logic       v;
    logic [5:0] note;
    logic       fr;
    logic [5:0] ep;
    logic [5:0] ec;
    logic [5:0] ef;
    logic       eb;
    logic       ed;
    logic [7:0] em;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: song contents, position, run length, misses and
  // the number of upcoming edges at which samples are not accepted.
  bit         model_on = 1'b0;
  logic [5:0] song [64];
  int         m_len, m_pos, m_run, m_miss, m_wait;
  bit         m_busy, m_done;
  logic [5:0] m_prev, m_cur, m_next;
  logic [5:0] m_past, m_curd, m_fut;

  task automatic applyStimulus(input logic wr, input logic [5:0] wa,
                               input logic [5:0] wd, input logic st,
                               input logic [6:0] len, input logic v,
                               input logic [5:0] note, input logic fr);
    bus.wr_en       = wr;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    bus.start       = st;
    bus.song_len    = len;
    bus.note_valid  = v;
    bus.note_in     = note;
    bus.frame_start = fr;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] ep,
                             input logic [5:0] ec, input logic [5:0] ef,
                             input logic eb, input logic ed,
                             input logic [7:0] em);
    tests++;
    if (bus.past !== ep || bus.current !== ec || bus.future !== ef ||
        bus.busy !== eb || bus.song_done !== ed || bus.miss_cnt !== em) begin
      fails++;
      $display("[TB] FAIL %s: got past=%0d cur=%0d fut=%0d busy=%0b done=%0b miss=%0d, want past=%0d cur=%0d fut=%0d busy=%0b done=%0b miss=%0d",
               name, bus.past, bus.current, bus.future, bus.busy,
               bus.song_done, bus.miss_cnt, ep, ec, ef, eb, ed, em);
    end
  endtask

  task automatic model_step();
    bit busy_pre;
    m_done = 1'b0;
    if (reset) begin
      m_busy = 0; m_wait = 0; m_pos = 0; m_run = 0; m_miss = 0; m_len = 0;
      m_prev = 0; m_cur = 0; m_next = 0;
      m_past = 0; m_curd = 0; m_fut = 0;
      return;
    end
    if (bus.frame_start) begin
      m_past = m_prev;
      m_curd = m_cur;
      m_fut  = m_next;
    end
    busy_pre = m_busy;
    if (m_wait > 0) begin
      m_wait--;
    end else if (m_busy) begin
      if (bus.note_valid) begin
        if (bus.note_in == m_cur) begin
          if (m_run + 1 == HOLD) begin
            m_prev = m_cur;
            m_run  = 0;
            if (m_pos == m_len - 1) begin
              m_cur  = 0;
              m_next = 0;
              m_done = 1'b1;
              m_busy = 1'b0;
            end else begin
              m_pos++;
              m_cur  = m_next;
              m_next = (m_pos + 1 < m_len) ? song[m_pos + 1] : 6'd0;
              m_wait = 1;
            end
          end else begin
            m_run++;
          end
        end else begin
          m_run = 0;
          if (bus.note_in != 0 && m_miss < 255) m_miss++;
        end
      end
    end else if (bus.start && bus.song_len >= 1 && bus.song_len <= 64) begin
      m_len  = int'(bus.song_len);
      m_pos  = 0;
      m_run  = 0;
      m_miss = 0;
      m_prev = 0;
      m_cur  = song[0];
      m_next = (m_len > 1) ? song[1] : 6'd0;
      m_busy = 1'b1;
      m_wait = 2;
    end
    if (bus.wr_en && !busy_pre) song[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with every input toggling: outputs must stay cleared.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom),
                    7'($urandom), 1'($urandom), 6'($urandom), 1'($urandom));
      tick();
      checkOutput($sformatf("reset%0d", i), 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // n, wr, wa, wd, st, len, v, note, fr | past, cur, fut, busy, done, miss
    vecs.push_back('{1,   1, 0, 12, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 0});
    vecs.push_back('{1,   1, 1, 14, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 0});
    vecs.push_back('{1,   1, 2, 16, 0, 0,  0, 0,  0,  0,  0,  0, 0, 0, 0});
    vecs.push_back('{1,   0, 0, 0,  1, 3,  0, 0,  0,  0,  0,  0, 1, 0, 0});
    vecs.push_back('{2,   0, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0, 1, 0, 0});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  0, 0,  1,  0, 12, 14, 1, 0, 0});
    vecs.push_back('{3,   0, 0, 0,  0, 0,  1, 12, 0,  0, 12, 14, 1, 0, 0});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  1, 16, 0,  0, 12, 14, 1, 0, 1});
    vecs.push_back('{3,   0, 0, 0,  0, 0,  1, 12, 0,  0, 12, 14, 1, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  1, 12, 1,  0, 12, 14, 1, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  1, 12, 0,  0, 12, 14, 1, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  0, 0,  1, 12, 14, 16, 1, 0, 1});
    vecs.push_back('{4,   0, 0, 0,  0, 0,  1, 14, 0, 12, 14, 16, 1, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  0, 0,  0, 12, 14, 16, 1, 0, 1});
    vecs.push_back('{1,   1, 0, 63, 0, 0,  0, 0,  0, 12, 14, 16, 1, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  0, 0,  1, 14, 16,  0, 1, 0, 1});
    vecs.push_back('{3,   0, 0, 0,  0, 0,  1, 16, 0, 14, 16,  0, 1, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  1, 16, 0, 14, 16,  0, 0, 1, 1});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  0, 0,  0, 14, 16,  0, 0, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  0, 0,  1, 16,  0,  0, 0, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  1, 0,  0, 0,  0, 16,  0,  0, 0, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  1, 65, 0, 0,  0, 16,  0,  0, 0, 0, 1});
    vecs.push_back('{1,   0, 0, 0,  1, 3,  0, 0,  0, 16,  0,  0, 1, 0, 0});
    vecs.push_back('{2,   0, 0, 0,  0, 0,  0, 0,  0, 16,  0,  0, 1, 0, 0});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  0, 0,  1,  0, 12, 14, 1, 0, 0});
    vecs.push_back('{3,   0, 0, 0,  0, 0,  1, 12, 0,  0, 12, 14, 1, 0, 0});
    vecs.push_back('{1,   0, 0, 0,  0, 0,  1, 0,  0,  0, 12, 14, 1, 0, 0});
    vecs.push_back('{3,   0, 0, 0,  0, 0,  1, 12, 1,  0, 12, 14, 1, 0, 0});
    vecs.push_back('{300, 0, 0, 0,  0, 0,  1, 5,  0,  0, 12, 14, 1, 0, 255});
    vecs.push_back('{4,   0, 0, 0,  0, 0,  1, 7,  0,  0, 12, 14, 1, 0, 255});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].st,
                    vecs[i].len, vecs[i].v, vecs[i].note, vecs[i].fr);
      repeat (vecs[i].n) tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].ep, vecs[i].ec, vecs[i].ef,
                  vecs[i].eb, vecs[i].ed, vecs[i].em);
    end

    // Reset in the middle of a song aborts everything to zero.
    applyStimulus(0, 0, 0, 0, 0, 1, 12, 1);
    reset = 1'b1;
    tick();
    checkOutput("midreset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("postreset", 0, 0, 0, 0, 0, 0);

    // Randomized run against the reference model.
    model_on = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1, 6'(a), 6'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
      tick();
    end
    for (int c = 0; c < 3000; c++) begin
      logic       wr, st, v, fr;
      logic [6:0] len;
      logic [5:0] note;
      int         pick;
      wr   = ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 29) == 0);
      pick = $urandom_range(0, 9);
      len  = (pick == 9) ? 7'd65 : 7'(pick);
      v    = 1'($urandom);
      note = ($urandom_range(0, 9) < 7) ? m_cur : 6'($urandom_range(0, 3));
      fr   = (m_wait == 0) && ($urandom_range(0, 7) == 0);
      applyStimulus(wr, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 3)),
                    st, len, v, note, fr);
      tick();
      checkOutput("random", m_past, m_curd, m_fut, m_busy, m_done, 8'(m_miss));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
